spi_bus_initiator: RTL and testbench

//  SPI master (mode 0, MSB first) that issues one register access per request to the

---
 rtl/spi_bus_initiator_pkg.sv | 31 +++
 rtl/address_map.vh | 11 +
 rtl/spi_shift_frame.sv | 84 ++++++++
 rtl/spi_bus_initiator.sv | 143 ++++++++++++++
 tb/tb_spi_bus_initiator.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_bus_initiator_pkg.sv
// Shared widths, protocol constants, FSM state codes and the command-byte builder
// for the SPI register-access initiator.
`include "address_map.vh"

package spi_bus_initiator_pkg;

    localparam int DW         = `DATA_WIDTH;
    localparam int AW         = `ADDR_WIDTH;
    localparam int CMD_WR_BIT = `SPI_CMD_WR_BIT;

    localparam logic [DW-1:0] ACK_BYTE   = `ACK;
    localparam logic [DW-1:0] DUMMY_BYTE = `SPI_DUMMY_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DATA = 3'd3,
        ST_TAIL = 3'd4
    } state_e;

    // Bits between the address field and the W/R flag are sent as zero.
    function automatic logic [DW-1:0] cmd_byte(input logic wr, input logic [AW-1:0] addr);
        logic [DW-1:0] b;
        b             = '0;
        b[AW-1:0]     = addr;
        b[CMD_WR_BIT] = wr;
        return b;
    endfunction

endpackage

// File: rtl/address_map.vh
// Board register-map constants shared by the SPI register responder and its initiator.
`ifndef ADDRESS_MAP_VH
`define ADDRESS_MAP_VH

`define DATA_WIDTH      8
`define ADDR_WIDTH      7
`define ACK             8'hC3
`define SPI_CMD_WR_BIT  (`DATA_WIDTH-1)
`define SPI_DUMMY_BYTE  8'h00

`endif

// File: rtl/spi_shift_frame.sv
// One mode-0, MSB-first SPI frame: CS_N low for a lead-in half-period plus eight
// full SCLK periods; rx byte is valid when o_done pulses.
module spi_shift_frame
    import spi_bus_initiator_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_tx_byte,
    output logic [DW-1:0] o_rx_byte,
    output logic          o_done,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_cs_n,
    input  logic          i_miso
);

    // Phase 0 is the lead-in, odd phases are SCLK high, even phases >= 2 are SCLK low.
    localparam int NPH = 2 * DW + 1;
    localparam int PW  = $clog2(NPH + 1);
    localparam int CW  = $clog2(CLK_DIV);

    localparam logic [PW-1:0] LAST_PH = PW'(NPH - 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] ph_q;
    logic [DW-1:0] tx_q;
    logic [DW-1:0] rx_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          cs_n_q;

    assign o_done    = active_q && (cnt_q == CNT_END) && (ph_q == LAST_PH);
    assign o_rx_byte = rx_q;
    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
        end else if (i_start && !active_q) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            ph_q     <= '0;
            tx_q     <= i_tx_byte;
            mosi_q   <= i_tx_byte[DW-1];
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b0;
        end else if (active_q) begin
            if (cnt_q == CNT_END) begin
                cnt_q <= '0;
                ph_q  <= ph_q + PW'(1);
                if (ph_q == LAST_PH) begin
                    // Chip select releases after the last low half-period.
                    active_q <= 1'b0;
                    cs_n_q   <= 1'b1;
                    mosi_q   <= 1'b0;
                end else if (!ph_q[0]) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[DW-2:0], i_miso};
                end else begin
                    sclk_q <= 1'b0;
                    mosi_q <= tx_q[DW-2];
                    tx_q   <= {tx_q[DW-2:0], 1'b0};
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_bus_initiator.sv
// SPI register-access initiator: command frame, CS_N gap, data frame, tail gap.
// Define SPI_INITIATOR_ACK_CHECK_EN to flag write completions whose ack byte is wrong.
module spi_bus_initiator
    import spi_bus_initiator_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_wr,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_rsp_valid,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_busy,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_cs_n,
    input  logic          i_miso
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_e        state_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic [GW-1:0] gap_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;

    logic          accept;
    logic          gap_done;
    logic          frame_start;
    logic          frame_done;
    logic [DW-1:0] frame_tx;
    logic [DW-1:0] frame_rx;

    assign accept      = i_req_valid && (state_q == ST_IDLE);
    assign gap_done    = (gap_q == GAP_LAST);
    assign frame_start = accept || ((state_q == ST_GAP) && gap_done);

    // The command byte comes straight from the request on the accept cycle.
    always_comb begin
        frame_tx = wr_q ? wdata_q : DUMMY_BYTE;
        if (state_q == ST_IDLE) begin
            frame_tx = cmd_byte(i_req_wr, i_req_addr);
        end
    end

    spi_shift_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (frame_start),
        .i_tx_byte (frame_tx),
        .o_rx_byte (frame_rx),
        .o_done    (frame_done),
        .o_sclk    (o_sclk),
        .o_mosi    (o_mosi),
        .o_cs_n    (o_cs_n),
        .i_miso    (i_miso)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= i_req_wr;
                        wdata_q <= i_req_wdata;
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (frame_done) begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_q <= ST_DATA;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                ST_DATA: begin
                    if (frame_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= frame_rx;
                        gap_q       <= '0;
                        state_q     <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (gap_done) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_INITIATOR_ACK_CHECK_EN
    logic rsp_err_q;

    // Reads never flag an error; writes flag any byte other than the ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_err_q <= 1'b0;
        end else if ((state_q == ST_DATA) && frame_done) begin
            rsp_err_q <= wr_q && (frame_rx != ACK_BYTE);
        end
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_bus_initiator.sv
// Bench for spi_bus_initiator: SPI responder model, MOSI/timing monitor and a
// response scoreboard; honours SPI_INITIATOR_ACK_CHECK_EN for expected error flags.
module tb_spi_bus_initiator;
    import spi_bus_initiator_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int GAP         = 16;
    localparam int FRAME_LOW   = 17 * CLK_DIV;
    localparam int ACCESS_SPAN = 2 * FRAME_LOW + 2 * GAP + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_req_valid = 1'b0;
    logic       i_req_wr = 1'b0;
    logic [6:0] i_req_addr = '0;
    logic [7:0] i_req_wdata = '0;
    logic       o_req_ready;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_rdata;
    logic       o_rsp_err;
    logic       o_busy;
    logic       o_sclk;
    logic       o_mosi;
    logic       o_cs_n;
    logic       miso = 1'b0;

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    int exp_total = 0;
    int idle_bad = 0;

    logic [8:0] exp_q[$];
    logic [7:0] exp_mosi_q[$];
    logic [7:0] miso_q[$];
    logic [8:0] last_rsp = '0;

    spi_bus_initiator #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wr    (i_req_wr),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy),
        .o_sclk      (o_sclk),
        .o_mosi      (o_mosi),
        .o_cs_n      (o_cs_n),
        .i_miso      (miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic wr, input logic [7:0] resp);
`ifdef SPI_INITIATOR_ACK_CHECK_EN
        return wr && (resp != ACK_BYTE);
`else
        return 1'b0 & wr & resp[0];
`endif
    endfunction

    // Responder model: first bit on CS_N fall, next bit on each SCLK fall.
    logic [7:0] miso_sh = '0;
    always @(negedge o_cs_n) begin
        if (rst_n) begin
            if (miso_q.size() > 0) miso_sh = miso_q.pop_front();
            else miso_sh = 8'h00;
            miso = miso_sh[7];
        end
    end
    always @(negedge o_sclk) begin
        if (o_cs_n == 1'b0) begin
            miso_sh = {miso_sh[6:0], 1'b0};
            miso = miso_sh[7];
        end
    end

    // Frame monitor and response scoreboard, sampled on the falling clock edge.
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       first_fall = 1'b1;
    logic       frame_idx = 1'b0;
    int         low_cnt = 0;
    int         high_cnt = 0;
    int         rises = 0;
    int         last_rise = 0;
    int         per_bad = 0;
    logic [7:0] mosi_sh = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
            first_fall = 1'b1;
            frame_idx = 1'b0;
            low_cnt = 0;
            high_cnt = 0;
        end else begin
            if (o_cs_n == 1'b0) begin
                if (prev_cs) begin
                    if (!first_fall) begin
                        if (frame_idx) check("cs_high_between_frames", high_cnt, GAP);
                        else check("cs_high_between_accesses_ge", high_cnt >= GAP + 1, 1);
                    end
                    first_fall = 1'b0;
                    low_cnt = 0;
                    rises = 0;
                    last_rise = 0;
                    per_bad = 0;
                    mosi_sh = '0;
                end
                low_cnt++;
                if (o_sclk && !prev_sclk) begin
                    if (rises > 0 && (low_cnt - last_rise) != 2 * CLK_DIV) per_bad++;
                    last_rise = low_cnt;
                    rises++;
                    mosi_sh = {mosi_sh[6:0], o_mosi};
                end
            end else begin
                if (!prev_cs) begin
                    check("cs_low_cycles", low_cnt, FRAME_LOW);
                    check("sclk_rises", rises, 8);
                    check("sclk_period_errors", per_bad, 0);
                    if (exp_mosi_q.size() == 0) check("mosi_unexpected_frame", 1, 0);
                    else check("mosi_frame", mosi_sh, exp_mosi_q.pop_front());
                    frame_idx = ~frame_idx;
                    high_cnt = 0;
                end
                high_cnt++;
                if (o_sclk !== 1'b0 || o_mosi !== 1'b0) idle_bad++;
            end
            prev_cs = o_cs_n;
            prev_sclk = o_sclk;

            if (o_rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    last_rsp = exp_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, last_rsp[7:0]);
                    check("rsp_err", o_rsp_err, last_rsp[8]);
                end
            end
        end
    end

    task automatic push_expect(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                               input logic [7:0] resp);
        miso_q.push_back(8'($urandom_range(0, 255)));
        miso_q.push_back(resp);
        exp_mosi_q.push_back({wr, addr});
        exp_mosi_q.push_back(wr ? wdata : 8'h00);
        exp_q.push_back({exp_err(wr, resp), resp});
        exp_total++;
    endtask

    task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_wr = wr;
        i_req_addr = addr;
        i_req_wdata = wdata;
        while (!o_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_in_budget", n < 1000, 1);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_wr = 1'($urandom_range(0, 1));
        i_req_addr = 7'($urandom_range(0, 127));
        i_req_wdata = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_cnt < exp_total && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_in_budget", rsp_cnt >= exp_total, 1);
        @(negedge clk);
        check("rsp_pulse_width", o_rsp_valid, 0);
        repeat (5) @(negedge clk);
        check("rsp_hold", {o_rsp_err, o_rsp_rdata}, last_rsp);
    endtask

    task automatic do_access(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                             input logic [7:0] resp);
        push_expect(wr, addr, wdata, resp);
        issue(wr, addr, wdata);
        wait_rsp();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic       wr;
        logic [7:0] resp;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cs_n", o_cs_n, 1);
        check("reset_sclk", o_sclk, 0);
        check("reset_mosi", o_mosi, 0);
        check("reset_req_ready", o_req_ready, 1);
        check("reset_rsp_valid", o_rsp_valid, 0);
        check("reset_rsp_rdata", o_rsp_rdata, 0);
        check("reset_rsp_err", o_rsp_err, 0);
        check("reset_busy", o_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_access(1'b1, 7'h12, 8'hA5, ACK_BYTE);
        do_access(1'b0, 7'h05, 8'h77, 8'h3C);
        do_access(1'b1, 7'h40, 8'h18, 8'hFF);

        for (int i = 0; i < 4; i++) begin
            wr = 1'($urandom_range(0, 1));
            resp = (wr && $urandom_range(0, 1) == 1) ? ACK_BYTE : 8'($urandom_range(0, 255));
            do_access(wr, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), resp);
        end

        // Two accesses with the request held valid throughout.
        push_expect(1'b1, 7'h21, 8'h4D, ACK_BYTE);
        push_expect(1'b0, 7'h6A, 8'h00, 8'h99);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_wr = 1'b1;
        i_req_addr = 7'h21;
        i_req_wdata = 8'h4D;
        n = 0;
        while (!o_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        i_req_wr = 1'b0;
        i_req_addr = 7'h6A;
        i_req_wdata = 8'h00;
        n = 0;
        while (!o_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_accept_spacing", n, ACCESS_SPAN);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        wait_rsp();

        // Reset in the middle of a read's data frame.
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h77);
        exp_mosi_q.push_back({1'b0, 7'h2B});
        issue(1'b0, 7'h2B, 8'h00);
        repeat (110) @(negedge clk);
        check("pre_reset_cs_low", o_cs_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", o_cs_n, 1);
        check("abort_sclk", o_sclk, 0);
        check("abort_busy", o_busy, 0);
        check("abort_req_ready", o_req_ready, 1);
        check("abort_rsp_valid", o_rsp_valid, 0);
        check("abort_rsp_rdata", o_rsp_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_response", rsp_cnt, exp_total);
        do_access(1'b0, 7'h33, 8'h00, 8'h5E);

        repeat (20) @(negedge clk);
        check("rsp_total", rsp_cnt, exp_total);
        check("exp_rsp_queue_empty", exp_q.size(), 0);
        check("exp_mosi_queue_empty", exp_mosi_q.size(), 0);
        check("miso_queue_empty", miso_q.size(), 0);
        check("idle_sclk_mosi_nonzero", idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
